// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared entry type and helpers for the CLA result FIFO
package cla_pkg;

  localparam int CLA_W = 8;

  typedef struct packed {
    logic             sub;
    logic             z;
    logic             cy;
    logic [CLA_W-1:0] sum;
  } cla_res_t;

  function automatic logic is_zero(input logic [CLA_W-1:0] v);
    return (v == '0);
  endfunction

endpackage

// File: rtl/cla_res_mem.sv
// rtl/cla_res_mem.sv - result storage, one sync write port and one async read port, no reset
module cla_res_mem #(
  parameter  int DEPTH = 8,
  parameter  int W     = 11,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cla_result_fifo.sv
// rtl/cla_result_fifo.sv - flagged result queue behind the CLA add/sub stage
// Optional drop counter built when CLA_RESULT_FIFO_DROP_CNT_EN is defined.
module cla_result_fifo
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_W,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH:0]           in_res,
  input  logic                     in_sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum,
  output logic                     out_cy,
  output logic                     out_z,
  output logic                     out_sub,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop_err,
  input  logic                     clr_err,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if (WIDTH != CLA_W) begin : g_width_chk
    $error("cla_result_fifo: WIDTH must equal cla_pkg::CLA_W");
  end

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic          primed;
  logic          drop_err_q;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;
  cla_res_t      wr_ent;
  cla_res_t      rd_ent;
  cla_res_t      head;

  assign full      = (level_q == LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && full && !pop;

  always_comb begin
    wr_ent     = '0;
    wr_ent.sub = in_sub;
    wr_ent.z   = is_zero(in_res[WIDTH-1:0]);
    wr_ent.cy  = in_res[WIDTH];
    wr_ent.sum = in_res[WIDTH-1:0];
  end

  cla_res_mem #(
    .DEPTH (DEPTH),
    .W     ($bits(cla_res_t))
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_ent),
    .raddr (rd_ptr),
    .rdata (rd_ent)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      primed  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        primed <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_err_q <= 1'b0;
    end else if (clr_err) begin
      drop_err_q <= 1'b0;
    end else if (drop) begin
      drop_err_q <= 1'b1;
    end
  end

`ifdef CLA_RESULT_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= 8'd0;
    end else if (clr_err) begin
      drop_cnt_q <= 8'd0;
    end else if (drop && drop_cnt_q != 8'hFF) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 8'd0;
`endif

  // Storage is never reset, so the head reads zero until something has been written.
  assign head     = primed ? rd_ent : '0;
  assign out_sum  = head.sum;
  assign out_cy   = head.cy;
  assign out_z    = head.z;
  assign out_sub  = head.sub;
  assign level    = level_q;
  assign drop_err = drop_err_q;

endmodule
